de2i_150_qsys_fir_sequencer: RTL and testbench
==============================================

# de2i_150_qsys_fir_sequencer

Sequencer that runs one FIR dot product over the shared 1024x32 dual-port FIR memory. It is configured through an Avalon-MM CSR slave. On start it drives memory port 2: it reads Q15 coefficients and a circular sample buffer, multiply-accumulates, then writes the scaled result back to memory. It sits between the Nios CSR fabric and memory port s2.

## Interface
Parameters:
- BUF_AW, 8, log2 of circular sample buffer length (buffer = 2^BUF_AW words).
- SHIFT, 15, arithmetic right shift applied to the accumulator before writeback.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  CSR word index.
- avs_read  in  1  CSR read strobe; readdata is combinational, zero wait states.
- avs_write  in  1  CSR write strobe.
- avs_writedata  in  32  CSR write data.
- avs_readdata  out  32  CSR read data.
- irq  out  1  equals STATUS.done.
- mem_address  out  10  memory port-2 word address.
- mem_chipselect  out  1  port-2 access enable.
- mem_write  out  1  port-2 write.
- mem_byteenable  out  4  always 4'hF.
- mem_writedata  out  32  result word.
- mem_readdata  in  32  port-2 read data, valid the cycle after the address is presented.

## Operation
CSR map (reset value 0 for all):
- 0 CTRL (WO): bit0 start, bit1 clear done/err.
- 1 STATUS (RO): bit0 busy, bit1 done, bit2 err.
- 2 TAPS [9:0].
- 3 COEF_BASE [9:0].
- 4 SAMPLE_BASE [9:0].
- 5 HEAD [BUF_AW-1:0].
- 6 RESULT_ADDR [9:0].
- 7 RESULT (RO, 32).
- Reads of unused bits return 0.

Control rules:
- Writes to regs 2–6 while busy are ignored. Start while busy is ignored.
- Start with TAPS==0 or TAPS>2^BUF_AW sets err, clears done, performs no memory access.
- A valid start clears done and err, zeroes the 40-bit signed accumulator, sets k=0 and busy=1.

FSM states: IDLE, RD_COEF, RD_SAMP, MAC, WRITE.
- IDLE: chipselect 0. A valid start goes to RD_COEF.
- RD_COEF: address = COEF_BASE+k (mod 1024), read. Go to RD_SAMP.
- RD_SAMP: capture coef = signed mem_readdata[15:0]. Address = SAMPLE_BASE + ((HEAD−k) & (2^BUF_AW−1)) (mod 1024), read. Go to MAC.
- MAC: chipselect 0. acc += coef × signed mem_readdata[15:0] (32-bit signed product, sign-extended). If k==TAPS−1 go to WRITE; else k++ and go to RD_COEF.
- WRITE: chipselect=1, write=1, address=RESULT_ADDR, writedata=acc[SHIFT+31:SHIFT]. In the same edge, RESULT is loaded with the same value, busy clears, done sets. Go to IDLE.

Other rules:
- Bits [31:16] of memory words are ignored on read.
- acc needs no saturation: 256×2^30 fits in 40 bits.
- CTRL bit1 and a valid start in the same write: start wins (done and err end cleared).
- Reset asynchronously returns the FSM to IDLE, with all CSRs, acc and k cleared, and all outputs 0.

## Timing
- Start write accepted at edge E0. First memory access (RD_COEF) occurs in the cycle after E0.
- Each tap takes 3 cycles. WRITE is 1 cycle.
- busy is high from E0+1 through the WRITE cycle.
- done/irq rise at edge E0 + 3·TAPS + 1.
- STATUS, RESULT and irq change only on clock edges. avs_readdata reflects register contents combinationally.
- Reset outputs: avs_readdata 0, irq 0, mem_chipselect 0, mem_write 0, mem_address 0, mem_writedata 0, mem_byteenable 4'hF.

## Test plan
- Reset: assert reset mid-cycle. Immediately irq=0 and mem_chipselect=0. All CSR reads return 0.
- Basic run: TAPS=4, COEF_BASE=0x000 holding 0x4000 ×4, SAMPLE_BASE=0x100 holding 100,200,300,400, HEAD=3, RESULT_ADDR=0x3FF. Expected: RESULT=500, memory[0x3FF]=500, done 13 cycles after start, irq=1.
- Wrap: BUF_AW=8, HEAD=1, TAPS=4. Sample reads go to 0x101, 0x100, 0x1FF, 0x1FE in that order. Coefficient reads go to 0x000–0x003.
- Sign: TAPS=1, coef 0xC000, sample 1000. Expected RESULT=0xFFFFFE0C (−500). Upper halfword garbage in memory words must not change the result.
- Illegal/conflict: TAPS=0 then start → err=1, no chipselect. Start and TAPS write during busy are ignored; the run result is unchanged. CTRL=2 clears err.
- Reset mid-run: assert reset during tap 2 of a 4-tap run. Expected: FSM in IDLE, busy=0, RESULT=0, no write to RESULT_ADDR. A subsequent reconfigure and start produces the correct result.

Source files
------------

// File: rtl/de2i_150_qsys_fir_sequencer_if.sv
// Bus bundle for the FIR sequencer: Avalon-MM CSR slave side plus memory port-2 master side.
// "slave" is the sequencer's view, "master" is the view of whatever drives the CSRs and models the memory.
interface de2i_150_qsys_fir_sequencer_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [9:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, mem_readdata,
        output avs_readdata, irq, mem_address, mem_chipselect, mem_write,
        output mem_byteenable, mem_writedata
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, mem_readdata,
        input  avs_readdata, irq, mem_address, mem_chipselect, mem_write,
        input  mem_byteenable, mem_writedata
    );
endinterface

// File: rtl/de2i_150_qsys_fir_sequencer.sv
// FIR dot-product sequencer: reads Q15 coefficients and a circular sample buffer over
// memory port 2, multiply-accumulates one tap every three cycles, then writes the scaled result back.
module de2i_150_qsys_fir_sequencer #(
    parameter int BUF_AW = 8,
    parameter int SHIFT  = 15
) (
    input  logic clk,
    input  logic reset,
    de2i_150_qsys_fir_sequencer_if.slave bus
);
    localparam int BUF_LEN = 1 << BUF_AW;

    typedef enum logic [2:0] {IDLE, RD_COEF, RD_SAMP, MAC, WRITE} state_t;

    state_t state, next_state;

    logic [9:0]         taps;
    logic [9:0]         coef_base;
    logic [9:0]         sample_base;
    logic [BUF_AW-1:0]  head;
    logic [9:0]         result_addr;
    logic [31:0]        result;
    logic               done;
    logic               err;
    logic signed [39:0] acc;
    logic [9:0]         k;
    logic signed [15:0] coef;

    logic               busy;
    logic               ctrl_wr;
    logic               cfg_wr;
    logic               start_req;
    logic               start_ok;
    logic               bad_taps;
    logic               last_tap;
    logic [BUF_AW-1:0]  samp_off;
    logic signed [15:0] samp;
    logic signed [31:0] prod;
    logic [31:0]        wb_word;
    logic [31:0]        readdata;
    logic [9:0]         mem_addr;
    logic               mem_cs;
    logic               mem_wr;
    logic [31:0]        mem_wdata;
    logic               unused_bits;

    assign busy      = (state != IDLE);
    assign ctrl_wr   = bus.avs_write && (bus.avs_address == 3'd0);
    assign cfg_wr    = bus.avs_write && !busy;
    assign start_req = ctrl_wr && bus.avs_writedata[0] && !busy;
    assign bad_taps  = (taps == 10'd0) || ({1'b0, taps} > 11'(BUF_LEN));
    assign start_ok  = start_req && !bad_taps;
    assign last_tap  = (k == taps - 10'd1);

    // Newest sample sits at HEAD; tap k walks backwards through the circular buffer.
    assign samp_off  = head - k[BUF_AW-1:0];
    assign samp      = $signed(bus.mem_readdata[15:0]);
    assign prod      = coef * samp;
    assign wb_word   = 32'(acc >>> SHIFT);

    assign unused_bits = ^{bus.avs_writedata[31:10], bus.mem_readdata[31:16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_cs     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start_ok) next_state = RD_COEF;
            end
            RD_COEF: begin
                mem_cs     = 1'b1;
                mem_addr   = coef_base + k;
                next_state = RD_SAMP;
            end
            RD_SAMP: begin
                mem_cs     = 1'b1;
                mem_addr   = sample_base + 10'(samp_off);
                next_state = MAC;
            end
            MAC: begin
                next_state = last_tap ? WRITE : RD_COEF;
            end
            WRITE: begin
                mem_cs     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = result_addr;
                mem_wdata  = wb_word;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // CSR writes first; the FSM-driven updates below take priority on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps        <= '0;
            coef_base   <= '0;
            sample_base <= '0;
            head        <= '0;
            result_addr <= '0;
            result      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            acc         <= '0;
            k           <= '0;
            coef        <= '0;
        end else begin
            if (cfg_wr) begin
                case (bus.avs_address)
                    3'd2: taps        <= bus.avs_writedata[9:0];
                    3'd3: coef_base   <= bus.avs_writedata[9:0];
                    3'd4: sample_base <= bus.avs_writedata[9:0];
                    3'd5: head        <= bus.avs_writedata[BUF_AW-1:0];
                    3'd6: result_addr <= bus.avs_writedata[9:0];
                    default: ;
                endcase
            end
            if (start_req) begin
                done <= 1'b0;
                err  <= bad_taps;
                if (!bad_taps) begin
                    acc <= '0;
                    k   <= '0;
                end
            end else if (ctrl_wr && bus.avs_writedata[1]) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            case (state)
                RD_SAMP: coef <= samp;
                MAC: begin
                    acc <= acc + 40'(prod);
                    if (!last_tap) k <= k + 10'd1;
                end
                WRITE: begin
                    result <= wb_word;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        if (bus.avs_read) begin
            case (bus.avs_address)
                3'd1: readdata = {29'd0, err, done, busy};
                3'd2: readdata = {22'd0, taps};
                3'd3: readdata = {22'd0, coef_base};
                3'd4: readdata = {22'd0, sample_base};
                3'd5: readdata[BUF_AW-1:0] = head;
                3'd6: readdata = {22'd0, result_addr};
                3'd7: readdata = result;
                default: readdata = '0;
            endcase
        end
    end

    assign bus.avs_readdata   = readdata;
    assign bus.irq            = done;
    assign bus.mem_address    = mem_addr;
    assign bus.mem_chipselect = mem_cs;
    assign bus.mem_write      = mem_wr;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_writedata  = mem_wdata;
endmodule

// File: tb/tb_de2i_150_qsys_fir_sequencer.sv
// Self-checking bench for the FIR sequencer: behavioural port-2 memory, scoreboard of expected writebacks.
module tb_de2i_150_qsys_fir_sequencer;
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    de2i_150_qsys_fir_sequencer_if bus();

    de2i_150_qsys_fir_sequencer #(.BUF_AW(8), .SHIFT(15)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] mem [0:1023];
    int          cs_count = 0;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [9:0]  rd_q[$];
    int          errors = 0;
    int          checks = 0;

    // Port-2 memory: registered read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            cs_count++;
            if (bus.mem_write) begin
                wr_t w;
                mem[bus.mem_address] = bus.mem_writedata;
                w.addr = bus.mem_address;
                w.data = bus.mem_writedata;
                wr_q.push_back(w);
            end else begin
                rd_q.push_back(bus.mem_address);
                bus.mem_readdata <= mem[bus.mem_address];
            end
        end
    end

    function automatic logic [31:0] model(input logic [9:0] cb, input logic [9:0] sb,
                                          input logic [7:0] hd, input logic [9:0] tp);
        longint a = 0;
        for (int i = 0; i < int'(tp); i++) begin
            logic [9:0] ca, sa;
            logic [7:0] off;
            logic signed [15:0] c, s;
            ca  = cb + 10'(i);
            off = hd - 8'(i);
            sa  = sb + {2'b00, off};
            c   = mem[ca][15:0];
            s   = mem[sa][15:0];
            a  += longint'(c) * longint'(s);
        end
        return 32'(a >>> 15);
    endfunction

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1 bus.avs_write  = 1'b0;
    endtask

    task automatic read_now(input logic [2:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        #1 d = bus.avs_readdata;
        bus.avs_read    = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        read_now(a, d);
    endtask

    task automatic configure(input logic [9:0] cb, input logic [9:0] sb, input logic [7:0] hd,
                             input logic [9:0] tp, input logic [9:0] ra);
        csr_write(3'd2, {22'd0, tp});
        csr_write(3'd3, {22'd0, cb});
        csr_write(3'd4, {22'd0, sb});
        csr_write(3'd5, {24'd0, hd});
        csr_write(3'd6, {22'd0, ra});
    endtask

    task automatic start_run(input logic [9:0] cb, input logic [9:0] sb, input logic [7:0] hd,
                             input logic [9:0] tp, input logic [9:0] ra, input logic [31:0] ctrl);
        wr_t e;
        e.addr = ra;
        e.data = model(cb, sb, hd, tp);
        exp_q.push_back(e);
        csr_write(3'd0, ctrl);
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit) begin
            @(posedge clk);
            cycles++;
            #1;
            if (bus.irq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        configure(10'h12, 10'h34, 8'h56, 10'd7, 10'h78);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.irq !== 1'b0 || bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs irq=%b cs=%b wr=%b required 0/0/0",
                     bus.irq, bus.mem_chipselect, bus.mem_write);
        end
        checks++;
        if (bus.mem_address !== 10'd0 || bus.mem_writedata !== 32'd0 || bus.mem_byteenable !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus addr=%h wd=%h be=%h required 0/0/F",
                     bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
        end
        for (int i = 0; i < 8; i++) begin
            read_now(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_csr%0d got %h required 0", i, d);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int cyc;
        bit ok;
        wr_t e, w;
        for (int i = 0; i < 4; i++) begin
            mem[i]         = 32'h0000_4000;
            mem[10'h100 + i] = 32'(100 * (i + 1));
        end
        configure(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FF);
        wr_q.delete();
        start_run(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FF, 32'd1);
        read_now(3'd1, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("[TB] FAIL basic_busy status=%h required 1", d);
        end
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != 13) begin
            errors++;
            $display("[TB] FAIL basic_latency done after %0d cycles (seen=%0d) required 13", cyc, ok);
        end
        csr_read(3'd1, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("[TB] FAIL basic_status got %h required 2", d);
        end
        csr_read(3'd7, d);
        checks++;
        if (d !== 32'd500) begin
            errors++;
            $display("[TB] FAIL basic_result got %0d required 500", d);
        end
        checks++;
        if (mem[10'h3FF] !== 32'd500) begin
            errors++;
            $display("[TB] FAIL basic_mem got %0d required 500", mem[10'h3FF]);
        end
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_write_count got %0d required 1", wr_q.size());
        end else begin
            e = exp_q.pop_front();
            w = wr_q.pop_front();
            checks++;
            if (w !== e) begin
                errors++;
                $display("[TB] FAIL basic_scoreboard got %h@%h required %h@%h", w.data, w.addr, e.data, e.addr);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_addr [8] = '{10'h000, 10'h101, 10'h001, 10'h100,
                                     10'h002, 10'h1FF, 10'h003, 10'h1FE};
        logic [9:0] got;
        int cyc;
        bit ok;
        wr_t e, w;
        mem[0] = 32'h0000_4000; mem[1] = 32'h0000_2000;
        mem[2] = 32'h0000_1000; mem[3] = 32'h0000_F000;
        mem[10'h101] = 32'd640; mem[10'h100] = 32'd320;
        mem[10'h1FF] = 32'd1600; mem[10'h1FE] = 32'hFFFF_FF00;
        configure(10'h000, 10'h100, 8'd1, 10'd4, 10'h3F0);
        rd_q.delete();
        wr_q.delete();
        start_run(10'h000, 10'h100, 8'd1, 10'd4, 10'h3F0, 32'd1);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || rd_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL wrap_reads got %0d reads (done=%0d) required 8", rd_q.size(), ok);
        end else begin
            for (int i = 0; i < 8; i++) begin
                got = rd_q.pop_front();
                checks++;
                if (got !== exp_addr[i]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr%0d got %h required %h", i, got, exp_addr[i]);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL wrap_write_count got %0d required 1", wr_q.size());
        end else begin
            w = wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("[TB] FAIL wrap_scoreboard got %h@%h required %h@%h", w.data, w.addr, e.data, e.addr);
            end
        end
    endtask

    task automatic test_sign();
        logic [31:0] d;
        int cyc;
        bit ok;
        wr_t e, w;
        mem[10'h010] = 32'hABCD_C000;
        mem[10'h200] = 32'h1234_03E8;
        configure(10'h010, 10'h200, 8'd0, 10'd1, 10'h3FE);
        wr_q.delete();
        start_run(10'h010, 10'h200, 8'd0, 10'd1, 10'h3FE, 32'd1);
        wait_done(50, cyc, ok);
        checks++;
        if (!ok || cyc != 4) begin
            errors++;
            $display("[TB] FAIL sign_latency done after %0d cycles (seen=%0d) required 4", cyc, ok);
        end
        csr_read(3'd7, d);
        checks++;
        if (d !== 32'hFFFF_FE0C) begin
            errors++;
            $display("[TB] FAIL sign_result got %h required FFFFFE0C", d);
        end
        e = exp_q.pop_front();
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL sign_write_count got %0d required 1", wr_q.size());
        end else begin
            w = wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("[TB] FAIL sign_scoreboard got %h@%h required %h@%h", w.data, w.addr, e.data, e.addr);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        int c0, cyc;
        bit ok;
        wr_t e, w;
        csr_write(3'd2, 32'd0);
        c0 = cs_count;
        csr_write(3'd0, 32'd1);
        repeat (4) @(posedge clk);
        csr_read(3'd1, d);
        checks++;
        if (d !== 32'd4 || cs_count != c0) begin
            errors++;
            $display("[TB] FAIL illegal_zero status=%h accesses=%0d required 4 and 0", d, cs_count - c0);
        end
        csr_write(3'd0, 32'd2);
        csr_read(3'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL illegal_clear status=%h required 0", d);
        end
        csr_write(3'd2, 32'd257);
        csr_write(3'd0, 32'd1);
        csr_read(3'd1, d);
        checks++;
        if (d !== 32'd4 || cs_count != c0) begin
            errors++;
            $display("[TB] FAIL illegal_257 status=%h accesses=%0d required 4 and 0", d, cs_count - c0);
        end
        for (int i = 0; i < 4; i++) mem[10'h100 + i] = 32'(100 * (i + 1));
        for (int i = 0; i < 4; i++) mem[i] = 32'h0000_4000;
        configure(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FD);
        wr_q.delete();
        start_run(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FD, 32'd1);
        csr_write(3'd2, 32'd1);
        csr_write(3'd6, 32'd0);
        csr_write(3'd0, 32'd1);
        wait_done(200, cyc, ok);
        csr_read(3'd2, d);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("[TB] FAIL conflict_taps got %0d required 4", d);
        end
        csr_read(3'd7, d);
        checks++;
        if (d !== 32'd500) begin
            errors++;
            $display("[TB] FAIL conflict_result got %0d required 500", d);
        end
        e = exp_q.pop_front();
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL conflict_write_count got %0d required 1", wr_q.size());
        end else begin
            w = wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("[TB] FAIL conflict_scoreboard got %h@%h required %h@%h", w.data, w.addr, e.data, e.addr);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        int cyc;
        bit ok;
        wr_t e, w;
        mem[10'h3FC] = 32'hDEAD_BEEF;
        configure(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FC);
        wr_q.delete();
        csr_write(3'd0, 32'd1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.irq !== 1'b0 || bus.mem_chipselect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs irq=%b cs=%b required 0/0", bus.irq, bus.mem_chipselect);
        end
        read_now(3'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_status got %h required 0", d);
        end
        read_now(3'd7, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_result got %h required 0", d);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        checks++;
        if (wr_q.size() != 0 || mem[10'h3FC] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL midrst_no_write writes=%0d mem=%h required 0 and DEADBEEF",
                     wr_q.size(), mem[10'h3FC]);
        end
        configure(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FC);
        start_run(10'h000, 10'h100, 8'd3, 10'd4, 10'h3FC, 32'd1);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != 13) begin
            errors++;
            $display("[TB] FAIL midrst_rerun_latency done after %0d cycles (seen=%0d) required 13", cyc, ok);
        end
        e = exp_q.pop_front();
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL midrst_write_count got %0d required 1", wr_q.size());
        end else begin
            w = wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("[TB] FAIL midrst_scoreboard got %h@%h required %h@%h", w.data, w.addr, e.data, e.addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int cyc;
        bit ok;
        wr_t e, w;
        for (int i = 0; i < 8; i++) begin
            mem[10'h020 + i] = $urandom_range(0, 32'hFFFF_FFFF);
            mem[10'h300 + i] = $urandom_range(0, 32'hFFFF_FFFF);
        end
        wr_q.delete();
        configure(10'h020, 10'h300, 8'd5, 10'd2, 10'h3E0);
        start_run(10'h020, 10'h300, 8'd5, 10'd2, 10'h3E0, 32'd1);
        wait_done(100, cyc, ok);
        configure(10'h022, 10'h300, 8'd7, 10'd5, 10'h3E1);
        start_run(10'h022, 10'h300, 8'd7, 10'd5, 10'h3E1, 32'd3);
        read_now(3'd1, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("[TB] FAIL b2b_start_wins status=%h required 1", d);
        end
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != 16) begin
            errors++;
            $display("[TB] FAIL b2b_latency done after %0d cycles (seen=%0d) required 16", cyc, ok);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d missing (writes=%0d expected=%0d)", i, wr_q.size(), exp_q.size());
            end else begin
                e = exp_q.pop_front();
                w = wr_q.pop_front();
                if (w !== e) begin
                    errors++;
                    $display("[TB] FAIL b2b_scoreboard%0d got %h@%h required %h@%h", i, w.data, w.addr, e.data, e.addr);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset             = 1'b1;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_sign();
        test_illegal();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
